hazard_unit_mc: RTL

Parametrised successor to the five-stage MIPS hazard unit. Adds multi-cycle data-memory wait handling, a multiply/divide-unit (MDU) busy scoreboard, and a saturating stall-cycle counter on top of load-use and branch stalls and E/D-stage forwarding. Sits beside the datapath and drives the F/D/E/M/W pipeline-register enables and clears, plus the forwarding muxes.

---
 rtl/hazard_unit_mc.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit_mc
// Purpose  : Hazard unit for a five-stage MIPS pipeline. It handles load-use,
//            branch and MDU-busy stalls, stretches the pipeline while the
//            data memory has not answered, and drives E/D-stage forwarding.
//            It also keeps a saturating count of stalled fetch cycles.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            BranchD .. RegWriteW          - stage control bits
//            RsD .. WriteRegW              - register indices (REG_W wide)
//            MemAccessM, MemReadyM         - M-stage memory handshake
//            MduStartE, MduUseD            - MDU issue in E / MDU use in D
//            ClrStats                      - clear the stall-cycle counter
//            StallF/D/E/M, FlushE/W        - pipeline register control
//            ForwardAD/BD, ForwardAE/BE    - forwarding mux selects
//            MduBusy, StallCycles          - MDU status, stall statistics
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit_mc #(
  parameter int REG_W   = 5,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BranchD,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegM,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [REG_W-1:0] RsD,
  input  logic [REG_W-1:0] RtD,
  input  logic [REG_W-1:0] RsE,
  input  logic [REG_W-1:0] RtE,
  input  logic [REG_W-1:0] WriteRegE,
  input  logic [REG_W-1:0] WriteRegM,
  input  logic [REG_W-1:0] WriteRegW,
  input  logic             MemAccessM,
  input  logic             MemReadyM,
  input  logic             MduStartE,
  input  logic             MduUseD,
  input  logic             ClrStats,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushE,
  output logic             FlushW,
  output logic             ForwardAD,
  output logic             ForwardBD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MduBusy,
  output logic [CNT_W-1:0] StallCycles
);

  // A zero latency still needs a one-bit register slot to keep widths legal.
  localparam int MCNT_W = (MDU_LAT > 0) ? $clog2(MDU_LAT + 1) : 1;

  logic              memwait;
  logic              lwstall;
  logic              branchstall;
  logic              mdustall;
  logic              mdu_busy;
  logic [MCNT_W-1:0] mcnt;

  // Ungated stall/flush decisions; the reset gating is applied at the ports.
  logic stall_front;
  logic stall_back;
  logic flush_e;
  logic flush_w;
  logic fwd_ad;
  logic fwd_bd;
  logic [1:0] fwd_ae;
  logic [1:0] fwd_be;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign memwait = MemAccessM & ~MemReadyM;

  assign lwstall = MemtoRegE & (WriteRegE != '0) &
                   ((WriteRegE == RsD) | (WriteRegE == RtD));

  assign branchstall = BranchD &
      ((RegWriteE & (WriteRegE != '0) & ((WriteRegE == RsD) | (WriteRegE == RtD))) |
       (MemtoRegM & (WriteRegM != '0) & ((WriteRegM == RsD) | (WriteRegM == RtD))));

  assign mdustall = MduUseD & mdu_busy;

  // A memory wait freezes every stage and outputs a bubble into W; the
  // D-stage stalls are deferred until the memory has answered, so a pending
  // load-use hazard is re-evaluated with the pipeline moving again.
  always_comb begin
    stall_front = 1'b0;
    stall_back  = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    if (memwait) begin
      stall_front = 1'b1;
      stall_back  = 1'b1;
      flush_w     = 1'b1;
    end else if (lwstall | branchstall | mdustall) begin
      stall_front = 1'b1;
      flush_e     = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding (independent of stalls; register 0 never forwards)
  // --------------------------------------------------------------------------
  assign fwd_ad = (RsD != '0) & (RsD == WriteRegM) & RegWriteM;
  assign fwd_bd = (RtD != '0) & (RtD == WriteRegM) & RegWriteM;

  always_comb begin
    fwd_ae = 2'b00;
    if ((RsE != '0) & (RsE == WriteRegM) & RegWriteM)
      fwd_ae = 2'b10;
    else if ((RsE != '0) & (RsE == WriteRegW) & RegWriteW)
      fwd_ae = 2'b01;
  end

  always_comb begin
    fwd_be = 2'b00;
    if ((RtE != '0) & (RtE == WriteRegM) & RegWriteM)
      fwd_be = 2'b10;
    else if ((RtE != '0) & (RtE == WriteRegW) & RegWriteW)
      fwd_be = 2'b01;
  end

  // --------------------------------------------------------------------------
  // Port drive: everything control-related reads as 0 while reset is high
  // --------------------------------------------------------------------------
  assign StallF    = ~reset & stall_front;
  assign StallD    = ~reset & stall_front;
  assign StallE    = ~reset & stall_back;
  assign StallM    = ~reset & stall_back;
  assign FlushE    = ~reset & flush_e;
  assign FlushW    = ~reset & flush_w;
  assign ForwardAD = ~reset & fwd_ad;
  assign ForwardBD = ~reset & fwd_bd;
  assign ForwardAE = reset ? 2'b00 : fwd_ae;
  assign ForwardBE = reset ? 2'b00 : fwd_be;
  assign MduBusy   = mdu_busy;

  // --------------------------------------------------------------------------
  // MDU scoreboard: a down-counter of cycles until the HI/LO result exists.
  // The load is gated on E advancing so a stalled op is counted once; the
  // decrement keeps running during memory waits because the MDU itself does.
  // --------------------------------------------------------------------------
  generate
    if (MDU_LAT > 0) begin : g_mdu_on
      always_ff @(posedge clk) begin
        if (reset) begin
          mcnt <= '0;
        end else if (MduStartE & ~stall_back) begin
          mcnt <= MCNT_W'(MDU_LAT);
        end else if (mcnt != '0) begin
          mcnt <= mcnt - 1'b1;
        end
      end
    end else begin : g_mdu_off
      logic unused_mdu_start;
      assign unused_mdu_start = MduStartE;
      assign mcnt = '0;
    end
  endgenerate

  assign mdu_busy = (mcnt != '0);

  // --------------------------------------------------------------------------
  // Stall statistics: saturating count of cycles with StallF asserted
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCycles <= '0;
    end else if (ClrStats) begin
      StallCycles <= '0;
    end else if (StallF && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule
`default_nettype wire
